call_ret_unit: RTL
==================

# call_ret_unit

Subroutine call/return sequencer for the processor's control path, driving the PC mux on `jal`/`ret`. On a call it pushes the return address (PC+1) onto an internal LIFO and redirects fetch to the jump target. On a return it pops the LIFO and redirects fetch to the popped address. It tracks stack depth, flags overflow and underflow, and holds fetch while a pop is in flight.

## Interface
- `AW`, 10, instruction address width
- `DEPTH`, 16, LIFO entries (power of two)
- `PW`, 4, pointer width, log2(DEPTH)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `call`  in  1  `jal` decoded this cycle
- `ret`  in  1  `ret` decoded this cycle
- `pc`  in  AW  address of the current instruction
- `target`  in  AW  `jal` jump target
- `err_clr`  in  1  clears the sticky error flags
- `redirect`  out  1  one-cycle pulse: fetch loads `pc_next`
- `pc_next`  out  AW  redirect address, registered
- `busy`  out  1  pop in flight; fetch holds, `call`/`ret` ignored
- `depth`  out  PW+1  valid entries, 0..DEPTH
- `empty`  out  1  depth == 0
- `full`  out  1  depth == DEPTH
- `ovf_err`  out  1  sticky: call attempted while full
- `unf_err`  out  1  sticky: ret attempted while empty

## Operation
- FSM states: IDLE, RET_RD, RET_GO.
  - IDLE to RET_RD on accepted ret.
  - RET_RD to RET_GO unconditionally.
  - RET_GO to IDLE unconditionally.
- `busy` = (state != IDLE).
- Call accepted only in IDLE:
  - If not full: write `pc+1` to mem[sp], sp++, depth++.
  - If full: no write, depth unchanged, set `ovf_err`.
  - In both cases, next cycle `redirect`=1 and `pc_next`=`target`. The jump is always taken.
- Ret accepted only in IDLE:
  - If not empty: sp--, depth--, issue a registered read of mem[sp-1], go to RET_RD.
  - In RET_GO: `redirect`=1, `pc_next`=read data.
  - If empty: set `unf_err`, stay in IDLE, no redirect.
- `call` and `ret` both high in IDLE: call wins, ret is dropped, no flag.
- `call`/`ret` while busy: ignored. No state change, no error.
- Return address `pc+1` wraps modulo 2^AW (0x3FF → 0x000).
- sp wraps modulo DEPTH. depth saturates at 0 and DEPTH by the rules above.
- `err_clr` clears both flags. If a new error occurs in the same cycle, the new error wins (flag set).
- Reset values: state IDLE, sp 0, depth 0, `empty`=1, `full`=0, `redirect`=0, `pc_next`=0, `busy`=0, both error flags 0. Memory contents are not reset.
- Reset asserted mid-RET_RD/RET_GO aborts the pop. No redirect is issued after reset release.

## Timing
- Call sampled at edge N: `redirect` high for cycle N→N+1. depth/full update at edge N.
- Ret sampled at edge N: depth updates at N; RET_RD during N→N+1; `redirect` high during N+1→N+2 (RET_GO). Latency is 2 cycles.
- `redirect` is always exactly one cycle wide and never asserted on two consecutive cycles for a single request.
- Next request accepted at the edge ending RET_GO (back-to-back ret: at N+2).
- Memory write is synchronous on the rising edge. Read data is registered, one cycle.
- No combinational path from inputs to outputs.

## Structure
- Shared package `cpu_pkg` holds:
  - `AW`, `DEPTH`, `PW` defaults.
  - FSM state enum `cr_state_t` {IDLE, RET_RD, RET_GO}.
- Sub-module `ret_stack_mem`: DEPTH×AW RAM, one synchronous write port, one registered read port. The remaining pointer, counter, FSM and flag logic stays in `call_ret_unit`.

## Test plan
1. **Reset values:** assert `reset`=0 mid-traffic → all outputs at their reset values and `empty`=1; release → nothing changes until the first call.
2. **Single call/return:** call `pc`=0x010, `target`=0x200 → next cycle `redirect`=1, `pc_next`=0x200, depth=1. Then ret → `busy`=1 for 2 cycles, redirect with `pc_next`=0x011, depth=0, `empty`=1.
3. **Nested LIFO order:** calls from 0x005, 0x105, 0x205, then 3 back-to-back rets → `pc_next` sequence 0x206, 0x106, 0x006. A call issued while `busy` is ignored (depth unchanged).
4. **Overflow:** 16 calls → `full`=1, depth=16. 17th call → `ovf_err`=1, depth stays 16, redirect to its target still issued. `err_clr` → `ovf_err`=0.
5. **Underflow:** ret while empty → `unf_err`=1, no redirect, `busy`=0. Simultaneous call+ret in IDLE → call only, depth+1.
6. **Wrap and reset abort:** call at `pc`=0x3FF; ret → `pc_next`=0x000. Second call, then ret, with `reset` pulsed during RET_RD → no redirect, depth=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared control-path definitions: default address/stack geometry and the
// call/return sequencer state encoding.
package cpu_pkg;

   localparam int AW    = 10;
   localparam int DEPTH = 16;
   localparam int PW    = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RET_RD = 2'd1,
      RET_GO = 2'd2
   } cr_state_t;

endpackage

// File: rtl/ret_stack_mem.sv
// Return-address RAM: one synchronous write port and one registered read
// port. Contents are deliberately left unreset.
module ret_stack_mem #(
   parameter int AW    = 10,
   parameter int DEPTH = 16,
   parameter int PW    = 4
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [PW-1:0] wr_addr,
   input  logic [AW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [PW-1:0] rd_addr,
   output logic [AW-1:0] rd_data
);

   logic [AW-1:0] mem [DEPTH];

   // Write and read share the clock; the sequencer never does both at once.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/call_ret_unit.sv
// Subroutine call/return sequencer: pushes return addresses on jal, pops them
// on ret and drives a registered one-cycle redirect to the fetch PC mux.
module call_ret_unit
   import cpu_pkg::*;
#(
   parameter int AW    = cpu_pkg::AW,
   parameter int DEPTH = cpu_pkg::DEPTH,
   parameter int PW    = cpu_pkg::PW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          call,
   input  logic          ret,
   input  logic [AW-1:0] pc,
   input  logic [AW-1:0] target,
   input  logic          err_clr,
   output logic          redirect,
   output logic [AW-1:0] pc_next,
   output logic          busy,
   output logic [PW:0]   depth,
   output logic          empty,
   output logic          full,
   output logic          ovf_err,
   output logic          unf_err
);

   cr_state_t     state;
   cr_state_t     state_nxt;
   logic [PW-1:0] sp;
   logic          do_push;
   logic          do_pop;
   logic          call_go;
   logic          load_ret;
   logic          ovf_set;
   logic          unf_set;
   logic [AW-1:0] rd_data;

   assign busy  = (state != IDLE);
   assign empty = (depth == '0);
   assign full  = (depth == (PW+1)'(DEPTH));

   ret_stack_mem #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (do_push),
      .wr_addr (sp),
      .wr_data (pc + AW'(1)),
      .rd_en   (do_pop),
      .rd_addr (sp - PW'(1)),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Requests are only looked at in IDLE; a call always beats a ret.
   always_comb begin
      state_nxt = state;
      do_push   = 1'b0;
      do_pop    = 1'b0;
      call_go   = 1'b0;
      load_ret  = 1'b0;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;
      case (state)
         IDLE: begin
            if (call) begin
               call_go = 1'b1;
               if (full) begin
                  ovf_set = 1'b1;
               end else begin
                  do_push = 1'b1;
               end
            end else if (ret) begin
               if (empty) begin
                  unf_set = 1'b1;
               end else begin
                  do_pop    = 1'b1;
                  state_nxt = RET_RD;
               end
            end
         end
         RET_RD: begin
            load_ret  = 1'b1;
            state_nxt = RET_GO;
         end
         RET_GO: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Redirect is registered, so it is high exactly in the cycle after a call
   // and throughout RET_GO for a return.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         redirect <= 1'b0;
         pc_next  <= '0;
         sp       <= '0;
         depth    <= '0;
         ovf_err  <= 1'b0;
         unf_err  <= 1'b0;
      end else begin
         redirect <= call_go | load_ret;
         if (call_go) begin
            pc_next <= target;
         end else if (load_ret) begin
            pc_next <= rd_data;
         end
         if (do_push) begin
            sp    <= sp + PW'(1);
            depth <= depth + (PW+1)'(1);
         end else if (do_pop) begin
            sp    <= sp - PW'(1);
            depth <= depth - (PW+1)'(1);
         end
         ovf_err <= ovf_set | (ovf_err & ~err_clr);
         unf_err <= unf_set | (unf_err & ~err_clr);
      end
   end

endmodule
